serial_frame_ctrl: RTL

Controller that sequences an 8-bit serial-in shift register to receive start/stop-framed bytes from a single-bit line `si`. It detects the start bit and enables the shift register for exactly `DATA_W` bit times. It then checks the stop bit and presents the assembled word on a valid/ready output port. It sits between the raw serial input and any byte-wide consumer, and reports framing and overrun errors.

---
 rtl/serial_pkg.sv | 5 +
 rtl/sipo_shreg.sv | 18 +
 rtl/serial_frame_ctrl.sv | 75 +++++++
 3 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding and default frame width for the serial receiver.
package serial_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, STOP} frame_state_t;
  localparam int DEFAULT_DATA_W = 8;
endpackage

// File: rtl/sipo_shreg.sv
// sipo_shreg: serial-in/parallel-out shift register with selectable shift direction.
module sipo_shreg #(
  parameter int W = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         si,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q, q_d;
  always_comb q_d = !en ? q_q : MSB_FIRST ? {q_q[W-2:0], si} : {si, q_q[W-1:1]};
  always_ff @(posedge clk or negedge rst)
    if (!rst) q_q <= '0;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/serial_frame_ctrl.sv
// serial_frame_ctrl: receives start/stop-framed words from si and presents them on a valid/ready port.
module serial_frame_ctrl import serial_pkg::*; #(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              si,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);
  localparam int CW = $clog2(DATA_W);
  frame_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d, sh;
  logic valid_q, valid_d, fe_q, fe_d, ov_q, ov_d, busy_q, busy_d, shift_en;
  assign shift_en = state_q == SHIFT;
  sipo_shreg #(.W(DATA_W), .MSB_FIRST(MSB_FIRST)) u_shreg (
    .clk(clk), .rst(rst), .en(shift_en), .si(si), .q(sh)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q && !ready;
    fe_d    = 1'b0;
    ov_d    = 1'b0;
    if (state_q == IDLE && !si) begin
      state_d = SHIFT;
      cnt_d   = '0;
    end
    if (state_q == SHIFT) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(DATA_W - 1)) state_d = STOP;
    end
    // A commit on the stop edge wins over a same-edge consume.
    if (state_q == STOP) begin
      state_d = IDLE;
      if (!si) fe_d = 1'b1;
      else if (valid_q && !ready) ov_d = 1'b1;
      else begin
        data_d  = sh;
        valid_d = 1'b1;
      end
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
      busy_q  <= busy_d;
    end
  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = fe_q;
  assign overrun   = ov_q;
  assign busy      = busy_q;
endmodule
